// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: data width, FSM and
// redirect-source encodings, and the layout of a buffered fetch.
package fetch_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

   typedef enum logic [1:0] {
      R_NONE = 2'd0,
      R_TRAP = 2'd1,
      R_EX   = 2'd2,
      R_ID   = 2'd3
   } redir_src_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous flush and occupancy count.
// Ports: i_flush clears, i_push/i_wdata write, i_pop advances head,
// o_rdata is the head, o_count/o_full/o_empty report occupancy.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];

   // A push into a full FIFO is still taken when the head leaves
   // in the same cycle.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push && !i_flush) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: redirect arbitration, credit-limited imem fetch,
// wrong-path response discard, fetch buffer to decode, debug halt.
// Ports: pc/pc_jump*/pc_stall_n to the PC register, trap/ex/id
// redirect inputs, imem_req/gnt/rvalid/rdata, if_* to decode,
// flush_if_id/flush_id_ex, halt_req/halted.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc,
   output logic            pc_jump,
   output logic [XLEN-1:0] pc_jump_addr,
   output logic            pc_stall_n,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_addr,
   input  logic            ex_redir_valid,
   input  logic [XLEN-1:0] ex_redir_addr,
   input  logic            id_jump_valid,
   input  logic [XLEN-1:0] id_jump_addr,
   output logic            imem_req,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            if_ready,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   input  logic            halt_req,
   output logic            halted
);

   localparam int SUM_W = CNT_W + 1;
   localparam logic [SUM_W-1:0] CREDITS = SUM_W'(DEPTH);

   fetch_state_e     r_state;
   fetch_state_e     w_state_nxt;
   redir_src_e       w_src;
   logic             w_redir;
   logic [CNT_W-1:0] r_discard;
   logic [CNT_W-1:0] w_outst;
   logic [CNT_W-1:0] w_outst_nxt;
   logic [CNT_W-1:0] w_buf_cnt;
   logic [SUM_W-1:0] w_inuse;
   logic             w_accept;
   logic             w_drop;
   logic             w_buf_push;
   logic             w_buf_pop;
   logic             w_buf_full;
   logic             w_buf_empty;
   logic             w_tag_full;
   logic             w_tag_empty;
   logic [XLEN-1:0]  w_tag;
   fetch_entry_t     w_push_entry;
   fetch_entry_t     w_head;

   // Redirect source, trap > ex > id; nothing is honoured in BOOT.
   always_comb begin
      w_src = R_NONE;
      if (r_state != BOOT) begin
         if (trap_valid) begin
            w_src = R_TRAP;
         end else if (ex_redir_valid) begin
            w_src = R_EX;
         end else if (id_jump_valid) begin
            w_src = R_ID;
         end
      end
   end

   always_comb begin
      pc_jump_addr = '0;
      unique case (w_src)
         R_TRAP:  pc_jump_addr = trap_addr;
         R_EX:    pc_jump_addr = ex_redir_addr;
         R_ID:    pc_jump_addr = id_jump_addr;
         default: pc_jump_addr = '0;
      endcase
   end

   assign w_redir     = (w_src != R_NONE);
   assign pc_jump     = w_redir;
   assign flush_if_id = w_redir;
   assign flush_id_ex = (w_src == R_TRAP) | (w_src == R_EX);

   // The head leaving this cycle frees its slot for a new fetch,
   // which is what lets a latency-1 memory stream at 1/cycle.
   assign w_inuse = {1'b0, w_outst} + {1'b0, w_buf_cnt}
                  - SUM_W'(w_buf_pop);

   assign imem_req = (r_state == RUN) & ~w_redir & ~halt_req
                   & (w_inuse < CREDITS);
   assign w_accept   = imem_req & imem_gnt;
   assign pc_stall_n = w_accept;

   assign w_outst_nxt = w_outst + CNT_W'(w_accept)
                      - CNT_W'(imem_rvalid);

   // Wrong-path responses: those already counted for discard, and
   // anything landing in the redirect cycle itself.
   assign w_drop     = w_redir | (r_discard != '0);
   assign w_buf_push = imem_rvalid & ~w_drop;

   assign w_push_entry.pc    = w_tag;
   assign w_push_entry.instr = imem_rdata;

   assign if_valid  = ~w_buf_empty & ~w_redir;
   assign if_pc     = w_head.pc;
   assign if_instr  = w_head.instr;
   assign w_buf_pop = if_valid & if_ready;

   assign halted = (r_state == HALTED);

   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_tag_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (1'b0),
      .i_push  (w_accept),
      .i_wdata (pc),
      .i_pop   (imem_rvalid),
      .o_rdata (w_tag),
      .o_count (w_outst),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty)
   );

   sync_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fetch_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_redir),
      .i_push  (w_buf_push),
      .i_wdata (w_push_entry),
      .i_pop   (w_buf_pop),
      .o_rdata (w_head),
      .o_count (w_buf_cnt),
      .o_full  (w_buf_full),
      .o_empty (w_buf_empty)
   );

   // On redirect every fetch still in flight after this cycle is
   // wrong-path; no new fetch is accepted in that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_discard <= '0;
      end else if (w_redir) begin
         r_discard <= w_outst_nxt;
      end else if (imem_rvalid && (r_discard != '0)) begin
         r_discard <= r_discard - 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         BOOT: w_state_nxt = RUN;
         RUN: begin
            if (halt_req) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_outst_nxt == '0) w_state_nxt = HALTED;
         end
         HALTED: begin
            if (!halt_req) w_state_nxt = RUN;
         end
         default: w_state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   a_buf_ovf: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_buf_push && w_buf_full && !w_buf_pop));

   a_tag_ovf: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_accept && w_tag_full));

   a_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rvalid && w_tag_empty));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: PC register and latency-1 imem
// models, one task per scenario with hand-computed expectations.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam logic [XLEN-1:0] MAGIC = 32'hA5A5_0000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [XLEN-1:0] pc;
   logic            pc_jump;
   logic [XLEN-1:0] pc_jump_addr;
   logic            pc_stall_n;
   logic            trap_valid;
   logic [XLEN-1:0] trap_addr;
   logic            ex_redir_valid;
   logic [XLEN-1:0] ex_redir_addr;
   logic            id_jump_valid;
   logic [XLEN-1:0] id_jump_addr;
   logic            imem_req;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            if_ready;
   logic            flush_if_id;
   logic            flush_id_ex;
   logic            halt_req;
   logic            halted;

   logic            resp_en;
   logic [XLEN-1:0] q[$];
   logic [102:0]    outs;
   int              total = 0;
   int              bad = 0;

   always #5 clk = ~clk;

   assign outs = {pc_jump, pc_jump_addr, pc_stall_n, imem_req,
                  if_valid, if_instr, if_pc, flush_if_id,
                  flush_id_ex, halted};

   fetch_ctrl #(.DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc             (pc),
      .pc_jump        (pc_jump),
      .pc_jump_addr   (pc_jump_addr),
      .pc_stall_n     (pc_stall_n),
      .trap_valid     (trap_valid),
      .trap_addr      (trap_addr),
      .ex_redir_valid (ex_redir_valid),
      .ex_redir_addr  (ex_redir_addr),
      .id_jump_valid  (id_jump_valid),
      .id_jump_addr   (id_jump_addr),
      .imem_req       (imem_req),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_ready       (if_ready),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .halt_req       (halt_req),
      .halted         (halted)
   );

   // PC register model.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= '0;
      else if (pc_jump) pc <= pc_jump_addr;
      else if (pc_stall_n) pc <= pc + 32'd4;
   end

   // In-order imem: response one cycle after grant while resp_en.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         imem_rvalid <= 1'b0;
         imem_rdata  <= '0;
      end else begin
         if (imem_rvalid && q.size() > 0) void'(q.pop_front());
         if (imem_req && imem_gnt) q.push_back(pc);
         imem_rvalid <= resp_en && (q.size() > 0);
         imem_rdata  <= (q.size() > 0) ? (q[0] ^ MAGIC) : '0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy, input logic ren);
      rst_n = 1'b0;
      trap_valid = 1'b0;
      trap_addr = '0;
      ex_redir_valid = 1'b0;
      ex_redir_addr = '0;
      id_jump_valid = 1'b0;
      id_jump_addr = '0;
      halt_req = 1'b0;
      imem_gnt = 1'b1;
      if_ready = rdy;
      resp_en = ren;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (outs !== '0) begin
         bad++;
         $display("FAIL rst_outs got=%h exp=0", outs);
      end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic check_boot_seq();
      total++;
      if (imem_req !== 1'b0) begin
         bad++;
         $display("FAIL boot_req got=%0b exp=0", imem_req);
      end
      tick(); #1;
      total++;
      if (imem_req !== 1'b1 || pc_stall_n !== 1'b1) begin
         bad++;
         $display("FAIL run_req got=%0b/%0b exp=1/1",
                  imem_req, pc_stall_n);
      end
      tick(); #1;
      total++;
      if (if_valid !== 1'b0) begin
         bad++;
         $display("FAIL lat_valid got=%0b exp=0", if_valid);
      end
      tick(); #1;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0
          || if_instr !== 32'hA5A5_0000) begin
         bad++;
         $display("FAIL if0 got=%0b %h %h exp=1 0 a5a50000",
                  if_valid, if_pc, if_instr);
      end
      tick(); #1;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
         bad++;
         $display("FAIL if4 got=%0b %h exp=1 4", if_valid, if_pc);
      end
      tick(); #1;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
         bad++;
         $display("FAIL if8 got=%0b %h exp=1 8", if_valid, if_pc);
      end
   endtask

   task automatic test_reset();
      do_reset(1'b1, 1'b1);
      check_boot_seq();
   endtask

   task automatic test_backpressure();
      do_reset(1'b0, 1'b1);
      tick(); #1;
      tick(); #1;
      total++;
      if (imem_req !== 1'b1 || pc_stall_n !== 1'b1) begin
         bad++;
         $display("FAIL bp_2nd got=%0b/%0b exp=1/1",
                  imem_req, pc_stall_n);
      end
      tick(); #1;
      total++;
      if (imem_req !== 1'b0 || pc_stall_n !== 1'b0) begin
         bad++;
         $display("FAIL bp_stop got=%0b/%0b exp=0/0",
                  imem_req, pc_stall_n);
      end
      tick(); #1;
      total++;
      if (imem_req !== 1'b0 || if_pc !== 32'h0) begin
         bad++;
         $display("FAIL bp_hold got=%0b %h exp=0 0", imem_req, if_pc);
      end
      tick();
      if_ready = 1'b1;
      #1;
      total++;
      if (imem_req !== 1'b1 || pc !== 32'h8) begin
         bad++;
         $display("FAIL bp_resume got=%0b %h exp=1 8", imem_req, pc);
      end
      tick(); #1;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
         bad++;
         $display("FAIL bp_if4 got=%0b %h exp=1 4", if_valid, if_pc);
      end
      tick(); #1;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8
          || if_instr !== 32'hA5A5_0008) begin
         bad++;
         $display("FAIL bp_if8 got=%0b %h %h exp=1 8 a5a50008",
                  if_valid, if_pc, if_instr);
      end
   endtask

   task automatic test_redirect();
      int n;
      do_reset(1'b1, 1'b0);
      id_jump_valid = 1'b1;
      id_jump_addr = 32'h10;
      #1;
      total++;
      if (pc_jump !== 1'b0 || flush_if_id !== 1'b0) begin
         bad++;
         $display("FAIL boot_redir got=%0b/%0b exp=0/0",
                  pc_jump, flush_if_id);
      end
      tick(); #1;
      total++;
      if (pc_jump !== 1'b1 || pc_jump_addr !== 32'h10
          || flush_id_ex !== 1'b0 || imem_req !== 1'b0) begin
         bad++;
         $display("FAIL id_redir got=%0b %h %0b %0b exp=1 10 0 0",
                  pc_jump, pc_jump_addr, flush_id_ex, imem_req);
      end
      tick();
      id_jump_valid = 1'b0;
      #1;
      tick(); #1;
      total++;
      if (imem_req !== 1'b1 || pc !== 32'h14) begin
         bad++;
         $display("FAIL rd_fetch got=%0b %h exp=1 14", imem_req, pc);
      end
      tick();
      ex_redir_valid = 1'b1;
      ex_redir_addr = 32'h100;
      resp_en = 1'b1;
      #1;
      total++;
      if ({pc_jump, flush_if_id, flush_id_ex, imem_req} !== 4'b1110
          || pc_jump_addr !== 32'h100) begin
         bad++;
         $display("FAIL ex_redir got=%0b%0b%0b%0b %h exp=1110 100",
                  pc_jump, flush_if_id, flush_id_ex, imem_req,
                  pc_jump_addr);
      end
      tick();
      ex_redir_valid = 1'b0;
      #1;
      n = 0;
      while (!if_valid && n < 12) begin
         tick(); #1;
         n++;
      end
      total++;
      if (if_valid !== 1'b1 || n != 3) begin
         bad++;
         $display("FAIL rd_wait got=%0b cyc=%0d exp=1 cyc=3",
                  if_valid, n);
      end
      total++;
      if (if_pc !== 32'h100 || if_instr !== 32'hA5A5_0100) begin
         bad++;
         $display("FAIL rd_target got=%h %h exp=100 a5a50100",
                  if_pc, if_instr);
      end
   endtask

   task automatic test_priority();
      tick();
      trap_valid = 1'b1;
      trap_addr = 32'h80;
      ex_redir_valid = 1'b1;
      ex_redir_addr = 32'h200;
      id_jump_valid = 1'b1;
      id_jump_addr = 32'h300;
      #1;
      total++;
      if (pc_jump_addr !== 32'h80 || flush_id_ex !== 1'b1) begin
         bad++;
         $display("FAIL pri_trap got=%h %0b exp=80 1",
                  pc_jump_addr, flush_id_ex);
      end
      trap_valid = 1'b0;
      #1;
      total++;
      if (pc_jump_addr !== 32'h200 || flush_id_ex !== 1'b1) begin
         bad++;
         $display("FAIL pri_ex got=%h %0b exp=200 1",
                  pc_jump_addr, flush_id_ex);
      end
      ex_redir_valid = 1'b0;
      #1;
      total++;
      if (pc_jump_addr !== 32'h300 || flush_id_ex !== 1'b0
          || flush_if_id !== 1'b1) begin
         bad++;
         $display("FAIL pri_id got=%h %0b %0b exp=300 0 1",
                  pc_jump_addr, flush_id_ex, flush_if_id);
      end
      id_jump_valid = 1'b0;
      #1;
      total++;
      if (pc_jump !== 1'b0 || flush_if_id !== 1'b0) begin
         bad++;
         $display("FAIL pri_none got=%0b %0b exp=0 0",
                  pc_jump, flush_if_id);
      end
   endtask

   task automatic test_halt();
      int n;
      do_reset(1'b1, 1'b0);
      tick(); #1;
      tick();
      halt_req = 1'b1;
      #1;
      total++;
      if (imem_req !== 1'b0 || halted !== 1'b0) begin
         bad++;
         $display("FAIL h_req got=%0b %0b exp=0 0", imem_req, halted);
      end
      tick();
      resp_en = 1'b1;
      #1;
      total++;
      if (halted !== 1'b0 || imem_req !== 1'b0) begin
         bad++;
         $display("FAIL h_drain got=%0b %0b exp=0 0", halted, imem_req);
      end
      tick(); #1;
      total++;
      if (halted !== 1'b0) begin
         bad++;
         $display("FAIL h_rsp got=%0b exp=0", halted);
      end
      tick(); #1;
      total++;
      if (halted !== 1'b1 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
         bad++;
         $display("FAIL h_halted got=%0b %0b %h exp=1 1 0",
                  halted, if_valid, if_pc);
      end
      tick();
      id_jump_valid = 1'b1;
      id_jump_addr = 32'h40;
      #1;
      total++;
      if ({pc_jump, halted, imem_req} !== 3'b110) begin
         bad++;
         $display("FAIL h_jump got=%0b%0b%0b exp=110",
                  pc_jump, halted, imem_req);
      end
      tick();
      id_jump_valid = 1'b0;
      halt_req = 1'b0;
      #1;
      total++;
      if (halted !== 1'b1 || imem_req !== 1'b0) begin
         bad++;
         $display("FAIL h_stay got=%0b %0b exp=1 0", halted, imem_req);
      end
      tick(); #1;
      total++;
      if (halted !== 1'b0 || imem_req !== 1'b1 || pc !== 32'h40) begin
         bad++;
         $display("FAIL h_resume got=%0b %0b %h exp=0 1 40",
                  halted, imem_req, pc);
      end
      n = 0;
      while (!if_valid && n < 12) begin
         tick(); #1;
         n++;
      end
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h40
          || if_instr !== 32'hA5A5_0040) begin
         bad++;
         $display("FAIL h_first got=%0b %h %h exp=1 40 a5a50040",
                  if_valid, if_pc, if_instr);
      end
   endtask

   task automatic test_async_reset();
      do_reset(1'b0, 1'b1);
      tick(); #1;
      tick(); #1;
      tick(); #1;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
         bad++;
         $display("FAIL ar_pre got=%0b %h exp=1 0", if_valid, if_pc);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (outs !== '0) begin
         bad++;
         $display("FAIL ar_outs got=%h exp=0", outs);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      if_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      check_boot_seq();
   endtask

   initial begin
      test_reset();
      test_backpressure();
      test_redirect();
      test_priority();
      test_halt();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
